// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between a UART TX client and uart_tx.
// The client drives data and start; the transmitter returns line and status.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits.
// Line format and bit time mirror the UART receiver so the two loop back.
module uart_tx #(
    parameter int BIT_TIME   = 434,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);
    localparam int CW = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nx;
    logic                  par;
    logic                  stop_cnt;
    logic                  tx_r;
    logic                  busy_r;
    logic                  done_r;

    logic end_bit;
    logic last_bit;
    logic last_stop;
    logic accept;
    logic par_in;

    assign end_bit   = (cnt == CW'(BIT_TIME - 1));
    assign last_bit  = (idx == IW'(DATA_WIDTH - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign shift_nx  = shift >> 1;
    assign par_in    = (^bus.tx_data) ^ (PARITY_ODD != 0);
    assign accept    = bus.tx_start && (state == IDLE || state == DONE);

    // Outputs are registered alongside the state, so each transition also
    // sets the line level the new state will present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            par      <= 1'b0;
            stop_cnt <= 1'b0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                state    <= START;
                shift    <= bus.tx_data;
                par      <= par_in;
                cnt      <= '0;
                idx      <= '0;
                stop_cnt <= 1'b0;
                tx_r     <= 1'b0;
                busy_r   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                    START: begin
                        cnt <= end_bit ? '0 : cnt + CW'(1);
                        if (end_bit) begin
                            state <= DATA;
                            tx_r  <= shift[0];
                        end
                    end
                    DATA: begin
                        cnt <= end_bit ? '0 : cnt + CW'(1);
                        if (end_bit) begin
                            shift <= shift_nx;
                            idx   <= idx + IW'(1);
                            if (!last_bit) begin
                                tx_r <= shift_nx[0];
                            end else if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_r  <= par;
                            end else begin
                                state <= STOP;
                                tx_r  <= 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= end_bit ? '0 : cnt + CW'(1);
                        if (end_bit) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end
                    end
                    STOP: begin
                        cnt <= end_bit ? '0 : cnt + CW'(1);
                        if (end_bit) begin
                            if (last_stop) begin
                                state    <= DONE;
                                stop_cnt <= 1'b0;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        idx    <= '0;
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx      = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: line traces are decoded into frames and
// compared against bit lists built from the byte, parity and stop settings.
module tb_uart_tx;
    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data;
    int         sel;

    always #5 clk = ~clk;

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    assign bus0.tx_data  = data;
    assign bus1.tx_data  = data;
    assign bus2.tx_data  = data;
    assign bus0.tx_start = start && (sel == 0);
    assign bus1.tx_start = start && (sel == 1);
    assign bus2.tx_start = start && (sel == 2);

    uart_tx #(.BIT_TIME(BT)) u_dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus0)
    );

    uart_tx #(
        .BIT_TIME(BT), .DATA_WIDTH(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) u_pe (
        .clk (clk),
        .rst (rst_n),
        .bus (bus1)
    );

    uart_tx #(
        .BIT_TIME(BT), .DATA_WIDTH(8), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2)
    ) u_po (
        .clk (clk),
        .rst (rst_n),
        .bus (bus2)
    );

    int pe_t[3] = '{0, 1, 1};
    int po_t[3] = '{0, 0, 1};
    int sb_t[3] = '{1, 1, 2};

    logic tx_s, busy_s, done_s;
    always_comb begin
        tx_s   = bus0.tx;
        busy_s = bus0.tx_busy;
        done_s = bus0.tx_done;
        case (sel)
            1: begin
                tx_s   = bus1.tx;
                busy_s = bus1.tx_busy;
                done_s = bus1.tx_done;
            end
            2: begin
                tx_s   = bus2.tx;
                busy_s = bus2.tx_busy;
                done_s = bus2.tx_done;
            end
            default: ;
        endcase
    end

    bit         rec;
    bit         q_tx[$];
    bit         q_busy[$];
    bit         q_done[$];
    bit         q_start[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rec) begin
            q_tx.push_back(tx_s);
            q_busy.push_back(busy_s);
            q_done.push_back(done_s);
            q_start.push_back(start);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic clear();
        q_tx.delete();
        q_busy.delete();
        q_done.delete();
        q_start.delete();
        exp_q.delete();
        rec = 1'b1;
    endtask

    task automatic pulse(logic [7:0] d);
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected line bits of one frame for the selected transmitter.
    task automatic frame_bits(logic [7:0] d, output bit eb[$]);
        bit p;
        eb.delete();
        eb.push_back(1'b0);
        for (int b = 0; b < 8; b++) eb.push_back(d[b]);
        p = (($countones(d) % 2) == 1) ^ (po_t[sel] != 0);
        if (pe_t[sel] != 0) eb.push_back(p);
        for (int s = 0; s < sb_t[sel]; s++) eb.push_back(1'b1);
    endtask

    task automatic analyse(bit lat, bit gap1);
        bit          eb[$];
        int          n;
        int          nf;
        int          ndone;
        int          idle_low;
        int          first_start;
        int          prev_end;
        int          len;
        int          ix;
        logic [31:0] obs;
        logic [31:0] e;
        n           = q_busy.size();
        nf          = 0;
        ndone       = 0;
        idle_low    = 0;
        first_start = -1;
        prev_end    = -1;
        for (int i = 0; i < n; i++)
            if (q_start[i] && first_start < 0) first_start = i;
        for (int i = 0; i < n; i++) begin
            if (q_done[i]) ndone++;
            if (!q_busy[i] && !q_tx[i]) idle_low++;
            if (q_busy[i] && (i == 0 || !q_busy[i-1])) begin
                if (nf < exp_q.size()) begin
                    frame_bits(exp_q[nf], eb);
                    len = 0;
                    while (i + len < n && q_busy[i+len]) len++;
                    check($sformatf("f%0d_busy_len", nf), len, eb.size() * BT);
                    for (int b = 0; b < eb.size(); b++) begin
                        obs = '0;
                        e   = eb[b] ? 32'((1 << BT) - 1) : 32'd0;
                        for (int k = 0; k < BT; k++) begin
                            ix = i + b * BT + k;
                            if (ix < n) obs[k] = q_tx[ix];
                        end
                        check($sformatf("f%0d_bit%0d", nf, b), obs, e);
                    end
                    check($sformatf("f%0d_done", nf),
                          (i + len < n) ? 32'(q_done[i+len]) : 32'd0, 1);
                    if (lat && nf == 0)
                        check("latency", i - first_start, 1);
                    if (gap1 && nf > 0)
                        check($sformatf("f%0d_gap", nf), i - prev_end, 1);
                    prev_end = i + len;
                end
                nf++;
            end
        end
        check("frames", nf, exp_q.size());
        check("done_cnt", ndone, exp_q.size());
        check("idle_high", idle_low, 0);
    endtask

    logic [7:0] bytes[256];
    int         t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
        sel   = 0;
        rec   = 1'b0;
        #12;
        check("rst_tx0", bus0.tx, 1);
        check("rst_busy0", bus0.tx_busy, 0);
        check("rst_done0", bus0.tx_done, 0);
        check("rst_tx1", bus1.tx, 1);
        check("rst_busy1", bus1.tx_busy, 0);
        check("rst_tx2", bus2.tx, 1);
        check("rst_busy2", bus2.tx_busy, 0);
        tick();
        rst_n = 1'b1;
        idle(3);

        // single 0x55 frame
        clear();
        idle(3);
        pulse(8'h55);
        exp_q.push_back(8'h55);
        idle(55);
        analyse(1, 0);

        // second request mid-frame is dropped
        clear();
        pulse(8'hA3);
        exp_q.push_back(8'hA3);
        idle(10);
        pulse(8'hFF);
        idle(50);
        analyse(1, 0);

        // start held high across two frames
        clear();
        data  = 8'h00;
        start = 1'b1;
        tick();
        idle(5);
        data = 8'h0F;
        idle(40);
        start = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h0F);
        idle(50);
        analyse(1, 1);

        // even parity, 1 stop bit
        sel = 1;
        clear();
        pulse(8'h07);
        exp_q.push_back(8'h07);
        idle(55);
        analyse(1, 0);
        clear();
        exp_q.push_back(8'($urandom));
        pulse(exp_q[0]);
        idle(55);
        analyse(1, 0);

        // odd parity, 2 stop bits
        sel = 2;
        clear();
        pulse(8'h07);
        exp_q.push_back(8'h07);
        idle(60);
        analyse(1, 0);

        // asynchronous reset three cycles into bit 4
        sel = 0;
        rec = 1'b0;
        idle(2);
        pulse(8'($urandom));
        idle(18);
        #1;
        check("busy_before_rst", bus0.tx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_tx", bus0.tx, 1);
        check("arst_busy", bus0.tx_busy, 0);
        check("arst_done", bus0.tx_done, 0);
        idle(2);
        rst_n = 1'b1;
        clear();
        idle(20);
        pulse(8'h3C);
        exp_q.push_back(8'h3C);
        idle(50);
        analyse(1, 0);

        // 256 random bytes back-to-back, decoded as a receiver would
        clear();
        for (int k = 0; k < 256; k++) begin
            bytes[k] = 8'($urandom);
            exp_q.push_back(bytes[k]);
        end
        data  = bytes[0];
        start = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            t = 0;
            tick();
            while (!done_s && t < 200) begin
                tick();
                t++;
            end
            if (t >= 200) begin
                check("loop_timeout", 0, 1);
                break;
            end
            if (k < 256) data = bytes[k];
            else start = 1'b0;
        end
        start = 1'b0;
        idle(10);
        analyse(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
